// File: rtl/calc_pkg.sv
// Shared encodings for the parametrised calculator controller: state codes seen on ESTADO,
// button bit positions and the button priority resolver.
package calc_pkg;

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StSoma = 3'd1,
    StSub  = 3'd2,
    StMult = 3'd3,
    StOn   = 3'd4,
    StDiv  = 3'd5
  } calc_state_e;

  localparam int unsigned BTN_SOMA  = 0;
  localparam int unsigned BTN_SUB   = 1;
  localparam int unsigned BTN_MULT  = 2;
  localparam int unsigned BTN_DIV   = 3;
  localparam int unsigned BTN_ONOFF = 4;
  localparam int unsigned NUM_BTN   = 5;

  // Keep only the highest-priority pulse: On/Off > Div > Mult > Sub > Soma.
  function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] p);
    logic [NUM_BTN-1:0] sel;
    sel = '0;
    if (p[BTN_ONOFF])     sel[BTN_ONOFF] = 1'b1;
    else if (p[BTN_DIV])  sel[BTN_DIV]   = 1'b1;
    else if (p[BTN_MULT]) sel[BTN_MULT]  = 1'b1;
    else if (p[BTN_SUB])  sel[BTN_SUB]   = 1'b1;
    else if (p[BTN_SOMA]) sel[BTN_SOMA]  = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/btn_release.sv
// One active-low push-button: 2-FF synchroniser, DEB-sample debounce and a one-cycle pulse
// on each accepted release (0 -> 1). Raw release to pulse is 2 + DEB cycles.
module btn_release #(
  parameter int unsigned DEB = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CntW = (DEB > 1) ? $clog2(DEB) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEB - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/calc_ctrl_param.sv
// Calculator controller: button release decoding, OFF/ON/operation FSM, one-cycle add/sub and
// W-cycle shift-add multiply / restoring divide sharing one work register. Requires W >= 2.
module calc_ctrl_param #(
  parameter int unsigned W   = 7,
  parameter int unsigned DEB = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [4:0]     B,
  input  logic [W-1:0]   N1,
  input  logic [W-1:0]   N2,
  output logic [2*W-1:0] RESULT,
  output logic           NEG,
  output logic           ERR,
  output logic           BUSY,
  output logic           VALID,
  output logic [2:0]     ESTADO
);
  import calc_pkg::*;

  localparam int unsigned CntW = $clog2(W + 1);

  logic [NUM_BTN-1:0] pulse, sel;
  calc_state_e        state_q, state_d, req;

  logic [2*W-1:0] result_q, result_d, acc_q, acc_d, acc_next;
  logic           neg_q, neg_d, err_q, err_d, busy_q, busy_d, valid_q, valid_d;
  logic [W-1:0]   snap_n1_q, snap_n1_d, snap_n2_q, snap_n2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           start;
  logic [W:0]     add_sum, mul_sum, div_top;
  logic [W-1:0]   sub_mag, div_rem;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_release #(.DEB(DEB)) u_btn (
      .CLK  (CLK),
      .RST_N(RST_N),
      .raw  (B[i]),
      .pulse(pulse[i])
    );
  end

  always_comb begin
    sel     = prio_pick(pulse);
    state_d = state_q;
    req     = StSoma;
    if (sel[BTN_DIV])       req = StDiv;
    else if (sel[BTN_MULT]) req = StMult;
    else if (sel[BTN_SUB])  req = StSub;
    if (state_q == StOff) begin
      if (sel[BTN_ONOFF]) state_d = StOn;
    end else if (sel[BTN_ONOFF]) begin
      state_d = StOff;
    end else if (sel != '0) begin
      state_d = (req == state_q) ? StOn : req;
    end
  end

  // One iteration of the active engine; MULT shifts right, DIV shifts left.
  always_comb begin
    add_sum = {1'b0, N1} + {1'b0, N2};
    sub_mag = (N1 >= N2) ? (N1 - N2) : (N2 - N1);
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, snap_n1_q};
    div_top = acc_q[2*W-1:W-1];
    div_rem = div_top[W-1:0] - snap_n2_q;
    if (state_q == StDiv) begin
      if (div_top >= {1'b0, snap_n2_q}) acc_next = {div_rem, acc_q[W-2:0], 1'b1};
      else                              acc_next = {div_top[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_next = {mul_sum, acc_q[W-1:1]};
      else          acc_next = {1'b0, acc_q[2*W-1:1]};
    end
  end

  always_comb begin
    result_d  = result_q;
    neg_d     = neg_q;
    err_d     = err_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    snap_n1_d = snap_n1_q;
    snap_n2_d = snap_n2_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    start     = 1'b0;

    if (state_d != state_q) begin
      // Any transition drops status and discards an in-flight iteration.
      valid_d = 1'b0;
      neg_d   = 1'b0;
      err_d   = 1'b0;
      busy_d  = 1'b0;
      if (state_d == StOff || state_d == StOn) result_d = '0;
      start = (state_d == StMult || state_d == StDiv);
    end else if ((state_q == StMult || state_q == StDiv) &&
                 (N1 != snap_n1_q || N2 != snap_n2_q)) begin
      start = 1'b1;
    end else begin
      unique case (state_q)
        StSoma: begin
          result_d = {{(W-1){1'b0}}, add_sum};
          neg_d    = 1'b0;
          valid_d  = 1'b1;
        end
        StSub: begin
          result_d = {{W{1'b0}}, sub_mag};
          neg_d    = (N1 < N2);
          valid_d  = 1'b1;
        end
        StMult, StDiv: begin
          if (busy_q) begin
            acc_d = acc_next;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(W - 1)) begin
              result_d = acc_next;
              busy_d   = 1'b0;
              valid_d  = 1'b1;
            end
          end else if (state_q == StDiv && snap_n2_q == '0) begin
            result_d = '0;
            err_d    = 1'b1;
            valid_d  = 1'b1;
          end
        end
        default: begin
          result_d = '0;
          neg_d    = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b0;
          valid_d  = 1'b0;
        end
      endcase
    end

    if (start) begin
      snap_n1_d = N1;
      snap_n2_d = N2;
      cnt_d     = '0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      busy_d    = !(state_d == StDiv && N2 == '0);
      acc_d     = (state_d == StDiv) ? {{W{1'b0}}, N1} : {{W{1'b0}}, N2};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StOff;
      result_q  <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      snap_n1_q <= '0;
      snap_n2_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      snap_n1_q <= snap_n1_d;
      snap_n2_q <= snap_n2_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
    end
  end

  assign RESULT = result_q;
  assign NEG    = neg_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;
  assign VALID  = valid_q;
  assign ESTADO = state_q;

endmodule

// File: tb/tb_calc_ctrl_param.sv
// Bench for calc_ctrl_param (W=7, DEB=4): directed button/operand sequences, valid results
// checked by a queue-based scoreboard, state/timing checked inline.
module tb_calc_ctrl_param;

  localparam int unsigned W   = 7;
  localparam int unsigned DEB = 4;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [4:0]     B;
  logic [W-1:0]   N1, N2;
  logic [2*W-1:0] RESULT;
  logic           NEG, ERR, BUSY, VALID;
  logic [2:0]     ESTADO;

  typedef struct {
    logic [2:0]     st;
    logic [2*W-1:0] res;
    logic           neg;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  calc_ctrl_param #(.W(W), .DEB(DEB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .B     (B),
    .N1    (N1),
    .N2    (N2),
    .RESULT(RESULT),
    .NEG   (NEG),
    .ERR   (ERR),
    .BUSY  (BUSY),
    .VALID (VALID),
    .ESTADO(ESTADO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [2:0] st, input int res, input logic neg, input logic err);
    exp_t e;
    e.st  = st;
    e.res = (2*W)'(res);
    e.neg = neg;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic press_release(input int idx, input int tail);
    B[idx] = 1'b0;
    tick(8);
    B[idx] = 1'b1;
    tick(tail);
  endtask

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    while (!BUSY && k < 20) begin
      tick(1);
      k++;
    end
    check(name, int'(BUSY), 1);
  endtask

  // Scoreboard monitor: a new valid presentation is VALID rising or a change while valid.
  initial begin
    logic           pv, pneg, perr;
    logic [2*W-1:0] pres;
    logic [2:0]     pst;
    exp_t           e;
    pv = 1'b0; pneg = 1'b0; perr = 1'b0; pres = '0; pst = '0;
    forever begin
      @(negedge CLK);
      if (RST_N && VALID &&
          (!pv || RESULT != pres || NEG != pneg || ERR != perr || ESTADO != pst)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_result", int'(RESULT), -1);
        end else begin
          e = exp_q.pop_front();
          check("sb_estado", int'(ESTADO), int'(e.st));
          check("sb_result", int'(RESULT), int'(e.res));
          check("sb_neg", int'(NEG), int'(e.neg));
          check("sb_err", int'(ERR), int'(e.err));
        end
      end
      pv   = RST_N && VALID;
      pres = RESULT;
      pneg = NEG;
      perr = ERR;
      pst  = ESTADO;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    RST_N = 1'b0;
    B     = 5'b11111;
    N1    = '0;
    N2    = '0;
    #3;
    check("reset_estado", int'(ESTADO), 0);
    check("reset_result", int'(RESULT), 0);
    check("reset_valid", int'(VALID), 0);
    check("reset_busy", int'(BUSY), 0);
    tick(2);
    RST_N = 1'b1;
    tick(2);

    // 1: power on, release-to-pulse latency, glitch rejection
    B[4] = 1'b0;
    tick(10);
    B[4] = 1'b1;
    tick(5);
    check("pulse_not_yet", int'(dut.pulse[4]), 0);
    tick(1);
    check("pulse_at_6", int'(dut.pulse[4]), 1);
    tick(1);
    check("on_estado", int'(ESTADO), 4);
    B[4] = 1'b0;
    tick(2);
    B[4] = 1'b1;
    tick(12);
    check("glitch_ignored", int'(ESTADO), 4);

    // 2: SOMA
    N1 = 7'd99; N2 = 7'd99;
    push(3'd1, 198, 1'b0, 1'b0);
    press_release(0, 12);
    check("soma_estado", int'(ESTADO), 1);
    N2 = 7'd1;
    push(3'd1, 100, 1'b0, 1'b0);
    tick(3);

    // 3: SUB entered straight from SOMA
    N1 = 7'd5; N2 = 7'd12;
    push(3'd1, 17, 1'b0, 1'b0);
    tick(3);
    push(3'd2, 7, 1'b1, 1'b0);
    press_release(1, 12);
    N1 = 7'd12; N2 = 7'd5;
    push(3'd2, 7, 1'b0, 1'b0);
    tick(3);

    // 4: MULT timing and restart
    N1 = 7'd127; N2 = 7'd127;
    push(3'd2, 0, 1'b0, 1'b0);
    tick(3);
    push(3'd3, 16129, 1'b0, 1'b0);
    B[2] = 1'b0;
    tick(8);
    B[2] = 1'b1;
    wait_busy("mult_busy_rise");
    bc = 0;
    while (BUSY && bc < 20) begin
      tick(1);
      bc++;
    end
    check("mult_busy_cycles", bc, 7);
    check("mult_estado", int'(ESTADO), 3);
    N1 = 7'd100;
    tick(3);
    check("mult_busy_mid", int'(BUSY), 1);
    N1 = 7'd3;
    push(3'd3, 381, 1'b0, 1'b0);
    tick(12);

    // 5: DIV normal and divide-by-zero
    N1 = 7'd100; N2 = 7'd7;
    push(3'd3, 700, 1'b0, 1'b0);
    tick(12);
    push(3'd5, (2 << 7) | 14, 1'b0, 1'b0);
    press_release(3, 20);
    check("div_estado", int'(ESTADO), 5);
    N2 = 7'd0;
    push(3'd5, 0, 1'b0, 1'b1);
    bc = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (BUSY) bc++;
    end
    check("div0_never_busy", bc, 0);
    check("div0_err", int'(ERR), 1);

    // 6: toggle off, simultaneous release, async reset mid-iteration
    push(3'd3, 0, 1'b0, 1'b0);
    press_release(2, 20);
    press_release(2, 12);
    check("mult_toggle_on", int'(ESTADO), 4);
    check("on_valid_low", int'(VALID), 0);
    N1 = 7'd20; N2 = 7'd22;
    push(3'd1, 42, 1'b0, 1'b0);
    press_release(0, 12);
    B = 5'b01110;
    tick(8);
    B = 5'b11111;
    tick(12);
    check("onoff_priority", int'(ESTADO), 0);
    check("off_result", int'(RESULT), 0);
    press_release(4, 12);
    N1 = 7'd127; N2 = 7'd127;
    B[2] = 1'b0;
    tick(8);
    B[2] = 1'b1;
    wait_busy("rst_busy_rise");
    tick(2);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_busy", int'(BUSY), 0);
    check("rst_estado", int'(ESTADO), 0);
    check("rst_result", int'(RESULT), 0);
    check("rst_valid", int'(VALID), 0);
    tick(2);
    RST_N = 1'b1;
    tick(4);
    check("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
